// File: rtl/timer_sched_pkg.sv
// Shared definitions for the timer scheduler: timer register map, control
// bits, FSM state encoding and period width.
// Optional feature macro: TIMER_SCHED_CANCEL_EN adds the WR_STOP state.
package timer_sched_pkg;

  localparam int PERIOD_W = 32;

  // Interval timer register offsets
  localparam logic [2:0] REG_STATUS  = 3'd0;
  localparam logic [2:0] REG_CONTROL = 3'd1;
  localparam logic [2:0] REG_PERIODL = 3'd2;
  localparam logic [2:0] REG_PERIODH = 3'd3;

  // Control register bits
  localparam logic [15:0] CTRL_ITO   = 16'h0001;
  localparam logic [15:0] CTRL_CONT  = 16'h0002;
  localparam logic [15:0] CTRL_START = 16'h0004;
  localparam logic [15:0] CTRL_STOP  = 16'h0008;

  // One-shot run with interrupt enabled (CONT deliberately left clear)
  localparam logic [15:0] CTRL_RUN_ONESHOT = CTRL_START | CTRL_ITO;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_PL,
    S_WR_PH,
    S_WR_CLR,
    S_WR_CTL,
    S_WAIT_IRQ,
    S_WR_STAT,
    S_DONE
`ifdef TIMER_SCHED_CANCEL_EN
    , S_WR_STOP
`endif
  } state_e;

  // A zero period would never expire; treat it as one clock
  function automatic logic [PERIOD_W-1:0] clamp_period(input logic [PERIOD_W-1:0] p);
    return (p == '0) ? PERIOD_W'(1) : p;
  endfunction

endpackage

// File: rtl/timer_sched_rr_arb.sv
// Combinational round-robin arbiter: the search starts one past the last
// granted requester and wraps modulo N_REQ.
module timer_sched_rr_arb #(
  parameter int N_REQ = 4,
  parameter int GW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [GW-1:0]    last_grant_i,
  output logic [GW-1:0]    grant_o,
  output logic             valid_o
);

  // First set request found walking forward from last_grant+1
  always_comb begin
    int unsigned idx;
    idx     = 0;
    grant_o = '0;
    valid_o = 1'b0;
    for (int unsigned off = 1; off <= N_REQ; off++) begin
      idx = (32'(last_grant_i) + off) % N_REQ;
      if (!valid_o && req_i[idx]) begin
        valid_o = 1'b1;
        grant_o = GW'(idx);
      end
    end
  end

endmodule

// File: rtl/timer_sched.sv
// Timer scheduler: grants one requester at a time, programs an interval
// timer over a simple write-only bus, waits for its interrupt and pulses
// done to the granted requester.
// Optional feature macro: TIMER_SCHED_CANCEL_EN adds cancel/cancelled.
module timer_sched #(
  parameter int N_REQ    = 4,
  parameter int PERIOD_W = timer_sched_pkg::PERIOD_W
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*PERIOD_W-1:0] req_period,
  output logic [N_REQ-1:0]          done,
  output logic                      busy,
  output logic [2:0]                avm_address,
  output logic                      avm_chipselect,
  output logic                      avm_write_n,
  output logic [15:0]               avm_writedata,
  input  logic                      timer_irq
`ifdef TIMER_SCHED_CANCEL_EN
  ,
  input  logic [N_REQ-1:0]          cancel,
  output logic [N_REQ-1:0]          cancelled
`endif
);

  import timer_sched_pkg::*;

  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_e              state_q, state_d;
  logic [GW-1:0]       grant_q, last_grant_q;
  logic [PERIOD_W-1:0] period_q;
  logic [PERIOD_W-1:0] sel_period;
  logic [GW-1:0]       arb_grant;
  logic                arb_valid;
`ifdef TIMER_SCHED_CANCEL_EN
  logic                cancel_q;
`endif

  timer_sched_rr_arb #(
    .N_REQ (N_REQ),
    .GW    (GW)
  ) u_arb (
    .req_i        (req),
    .last_grant_i (last_grant_q),
    .grant_o      (arb_grant),
    .valid_o      (arb_valid)
  );

  // Period slice belonging to the requester the arbiter would grant now
  always_comb begin
    sel_period = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (arb_grant == GW'(i)) sel_period = req_period[i*PERIOD_W +: PERIOD_W];
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; each write state lasts exactly one cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (arb_valid) state_d = S_WR_PL;
      S_WR_PL:    state_d = S_WR_PH;
      S_WR_PH:    state_d = S_WR_CLR;
      S_WR_CLR:   state_d = S_WR_CTL;
      S_WR_CTL:   state_d = S_WAIT_IRQ;
      S_WAIT_IRQ: begin
        // irq takes priority over a simultaneous cancel
        if (timer_irq) state_d = S_WR_STAT;
`ifdef TIMER_SCHED_CANCEL_EN
        else if (cancel[grant_q]) state_d = S_WR_STOP;
`endif
      end
`ifdef TIMER_SCHED_CANCEL_EN
      S_WR_STOP:  state_d = S_WR_STAT;
      S_WR_STAT:  state_d = cancel_q ? S_IDLE : S_DONE;
`else
      S_WR_STAT:  state_d = S_DONE;
`endif
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Grant/period capture in IDLE, last_grant update on entry to DONE
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      grant_q      <= '0;
      last_grant_q <= GW'(N_REQ - 1);
      period_q     <= '0;
`ifdef TIMER_SCHED_CANCEL_EN
      cancel_q     <= 1'b0;
`endif
    end else begin
      if (state_q == S_IDLE && arb_valid) begin
        grant_q  <= arb_grant;
        period_q <= clamp_period(sel_period);
      end
      if (state_d == S_DONE && state_q != S_DONE) last_grant_q <= grant_q;
`ifdef TIMER_SCHED_CANCEL_EN
      if (state_q == S_WR_STOP)      cancel_q <= 1'b1;
      else if (state_q == S_WR_STAT) cancel_q <= 1'b0;
`endif
    end
  end

  // Moore outputs: bus strobes, busy and completion pulses
  always_comb begin
    avm_chipselect = 1'b0;
    avm_write_n    = 1'b1;
    avm_address    = '0;
    avm_writedata  = '0;
    busy           = (state_q != S_IDLE);
    done           = '0;
`ifdef TIMER_SCHED_CANCEL_EN
    cancelled      = '0;
`endif
    case (state_q)
      S_WR_PL: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = REG_PERIODL;
        avm_writedata  = period_q[15:0];
      end
      S_WR_PH: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = REG_PERIODH;
        avm_writedata  = period_q[31:16];
      end
      S_WR_CLR: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = REG_STATUS;
      end
      S_WR_CTL: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = REG_CONTROL;
        avm_writedata  = CTRL_RUN_ONESHOT;
      end
      S_WR_STAT: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = REG_STATUS;
`ifdef TIMER_SCHED_CANCEL_EN
        if (cancel_q) cancelled[grant_q] = 1'b1;
`endif
      end
`ifdef TIMER_SCHED_CANCEL_EN
      S_WR_STOP: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = REG_CONTROL;
        avm_writedata  = CTRL_STOP;
      end
`endif
      S_DONE: done[grant_q] = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_timer_sched.sv
// Directed self-checking bench for timer_sched (N_REQ=4).
module tb_timer_sched;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N-1:0]    req;
  logic [N*32-1:0] req_period;
  logic [N-1:0]    done;
  logic            busy;
  logic [2:0]      avm_address;
  logic            avm_chipselect;
  logic            avm_write_n;
  logic [15:0]     avm_writedata;
  logic            timer_irq;
`ifdef TIMER_SCHED_CANCEL_EN
  logic [N-1:0]    cancel;
  logic [N-1:0]    cancelled;
`endif

  int checks = 0;
  int errors = 0;

  logic [25:0] obs;
  assign obs = {busy, done, avm_chipselect, avm_write_n, avm_address, avm_writedata};

  always #5 clk = ~clk;

  timer_sched #(.N_REQ(N), .PERIOD_W(32)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req            (req),
    .req_period     (req_period),
    .done           (done),
    .busy           (busy),
    .avm_address    (avm_address),
    .avm_chipselect (avm_chipselect),
    .avm_write_n    (avm_write_n),
    .avm_writedata  (avm_writedata),
    .timer_irq      (timer_irq)
`ifdef TIMER_SCHED_CANCEL_EN
    ,
    .cancel         (cancel),
    .cancelled      (cancelled)
`endif
  );

  // Expected {busy, done, cs, write_n, addr, data}
  function automatic logic [25:0] ev(input logic b, input logic [3:0] d, input logic wr,
                                     input logic [2:0] a, input logic [15:0] wd);
    return {b, d, wr, ~wr, (wr ? a : 3'd0), (wr ? wd : 16'd0)};
  endfunction

  // Expected vector for cycle c of a transaction (c=0 is WR_PL, irq during c=4)
  function automatic logic [25:0] txn_exp(input int g, input logic [31:0] p, input int c);
    logic [3:0] d;
    d = 4'b0001 << g;
    case (c)
      0:       return ev(1'b1, 4'b0, 1'b1, 3'd2, p[15:0]);
      1:       return ev(1'b1, 4'b0, 1'b1, 3'd3, p[31:16]);
      2:       return ev(1'b1, 4'b0, 1'b1, 3'd0, 16'h0000);
      3:       return ev(1'b1, 4'b0, 1'b1, 3'd1, 16'h0005);
      4:       return ev(1'b1, 4'b0, 1'b0, 3'd0, 16'h0000);
      5:       return ev(1'b1, 4'b0, 1'b1, 3'd0, 16'h0000);
      6:       return ev(1'b1, d,    1'b0, 3'd0, 16'h0000);
      default: return ev(1'b0, 4'b0, 1'b0, 3'd0, 16'h0000);
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [25:0] e;
    e = ev(1'b0, 4'b0, 1'b0, 3'd0, 16'h0);
    reset_n = 1'b0;
    tick;
    tick;
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL reset_state: got %h expected %h", obs, e);
    end
    reset_n = 1'b1;
    tick;
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL reset_idle_hold: got %h expected %h", obs, e);
    end
  endtask

  task automatic test_fairness;
    logic [25:0] e;
    int g;
    req_period = {32'd4, 32'd3, 32'd2, 32'd1};
    req = 4'b1111;
    tick;
    for (int t = 0; t < 5; t++) begin
      g = t % 4;
      for (int c = 0; c < 8; c++) begin
        e = txn_exp(g, 32'(g + 1), c);
        checks++;
        if (obs !== e) begin
          errors++;
          $display("FAIL fairness t%0d c%0d: got %h expected %h", t, c, obs, e);
        end
        timer_irq = (c == 4);
        if (c == 6 && t == 4) req = '0;
        tick;
      end
    end
  endtask

  task automatic test_single;
    logic [25:0] e;
    req_period[31:0] = 32'd10;
    req = 4'b0001;
    tick;
    for (int c = 0; c < 8; c++) begin
      e = txn_exp(0, 32'd10, c);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL single c%0d: got %h expected %h", c, obs, e);
      end
      timer_irq = (c == 4);
      if (c == 6) req = '0;
      tick;
    end
    e = ev(1'b0, 4'b0, 1'b0, 3'd0, 16'h0);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL single_stays_idle: got %h expected %h", obs, e);
    end
  endtask

  task automatic test_period;
    logic [25:0] e;
    req_period[95:64] = 32'h0001_2345;
    req = 4'b0100;
    tick;
    for (int c = 0; c < 8; c++) begin
      e = txn_exp(2, 32'h0001_2345, c);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL period_wide c%0d: got %h expected %h", c, obs, e);
      end
      timer_irq = (c == 4);
      if (c == 6) req_period[95:64] = 32'h0;
      tick;
    end
    for (int c = 0; c < 8; c++) begin
      e = txn_exp(2, 32'h0000_0001, c);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL period_zero c%0d: got %h expected %h", c, obs, e);
      end
      timer_irq = (c == 4);
      if (c == 6) req = '0;
      tick;
    end
  endtask

  task automatic test_stale_irq;
    logic [25:0] e;
    e = ev(1'b0, 4'b0, 1'b0, 3'd0, 16'h0);
    timer_irq = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL stale_irq_idle %0d: got %h expected %h", i, obs, e);
      end
    end
    req_period[63:32] = 32'd7;
    req = 4'b0010;
    tick;
    for (int c = 0; c < 8; c++) begin
      e = txn_exp(1, 32'd7, c);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL stale_irq c%0d: got %h expected %h", c, obs, e);
      end
      timer_irq = (c <= 4);
      if (c == 6) req = '0;
      tick;
    end
  endtask

  task automatic test_req_drop;
    logic [25:0] e;
    req_period[31:0] = 32'd5;
    req = 4'b0001;
    tick;
    for (int c = 0; c < 8; c++) begin
      e = txn_exp(0, 32'd5, c);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL req_drop c%0d: got %h expected %h", c, obs, e);
      end
      timer_irq = (c == 4);
      if (c == 1) req = '0;
      tick;
    end
  endtask

  task automatic test_reset_mid;
    logic [25:0] e;
    req_period[127:96] = 32'd99;
    req = 4'b1000;
    tick;
    for (int c = 0; c < 5; c++) begin
      e = txn_exp(3, 32'd99, c);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL reset_mid_pre c%0d: got %h expected %h", c, obs, e);
      end
      tick;
    end
    reset_n = 1'b0;
    tick;
    e = ev(1'b0, 4'b0, 1'b0, 3'd0, 16'h0);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL reset_mid_idle: got %h expected %h", obs, e);
    end
    reset_n = 1'b1;
    req_period = {32'h44, 32'h33, 32'h22, 32'h11};
    req = 4'b1111;
    tick;
    for (int c = 0; c < 8; c++) begin
      e = txn_exp(0, 32'h11, c);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL reset_mid_regrant c%0d: got %h expected %h", c, obs, e);
      end
      timer_irq = (c == 4);
      if (c == 6) req = '0;
      tick;
    end
  endtask

`ifdef TIMER_SCHED_CANCEL_EN
  task automatic test_cancel;
    logic [25:0] e;
    req_period[63:32] = 32'd3;
    req = 4'b0010;
    tick;
    for (int c = 0; c < 5; c++) begin
      e = txn_exp(1, 32'd3, c);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL cancel_pre c%0d: got %h expected %h", c, obs, e);
      end
      if (c == 4) cancel = 4'b0010;
      tick;
    end
    cancel = '0;
    e = ev(1'b1, 4'b0, 1'b1, 3'd1, 16'h0008);
    checks++;
    if (obs !== e || cancelled !== 4'b0000) begin
      errors++;
      $display("FAIL cancel_stop: got %h/%b expected %h/0000", obs, cancelled, e);
    end
    tick;
    e = ev(1'b1, 4'b0, 1'b1, 3'd0, 16'h0000);
    checks++;
    if (obs !== e || cancelled !== 4'b0010) begin
      errors++;
      $display("FAIL cancel_stat: got %h/%b expected %h/0010", obs, cancelled, e);
    end
    req = '0;
    tick;
    e = ev(1'b0, 4'b0, 1'b0, 3'd0, 16'h0000);
    checks++;
    if (obs !== e || cancelled !== 4'b0000) begin
      errors++;
      $display("FAIL cancel_idle: got %h/%b expected %h/0000", obs, cancelled, e);
    end
    req = 4'b0010;
    tick;
    for (int c = 0; c < 8; c++) begin
      e = txn_exp(1, 32'd3, c);
      checks++;
      if (obs !== e || cancelled !== 4'b0000) begin
        errors++;
        $display("FAIL cancel_vs_irq c%0d: got %h/%b expected %h/0000", c, obs, cancelled, e);
      end
      timer_irq = (c == 4);
      cancel    = (c == 4) ? 4'b0010 : 4'b0000;
      if (c == 6) req = '0;
      tick;
    end
  endtask
`endif

  initial begin
    reset_n    = 1'b0;
    req        = '0;
    req_period = '0;
    timer_irq  = 1'b0;
`ifdef TIMER_SCHED_CANCEL_EN
    cancel     = '0;
`endif
    test_reset;
    test_fairness;
    test_single;
    test_period;
    test_stale_irq;
    test_req_drop;
    test_reset_mid;
`ifdef TIMER_SCHED_CANCEL_EN
    test_cancel;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
